// File: rtl/des_pkg.sv
// DES constants, permutation helpers, key-schedule tables and engine state type.
package des_pkg;

   localparam int unsigned BLK_W = 64;
   localparam int unsigned HALF_W = 32;
   localparam int unsigned CD_W = 28;
   localparam int unsigned KEY_W = 48;
   localparam int unsigned RND_W = 4;
   localparam logic [RND_W-1:0] RND_LAST = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Tables hold FIPS 1-based bit numbers; FIPS bit n of a W-bit vector is index W-n.
   localparam int unsigned IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

   localparam int unsigned FP_T [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

   localparam int unsigned E_T [48] = '{
      32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

   localparam int unsigned P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

   localparam int unsigned PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

   localparam int unsigned PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

   // Encrypt rotates left; decrypt rotates right starting from the unrotated CD (K16).
   localparam logic [1:0] ENC_SH [16] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
   localparam logic [1:0] DEC_SH [16] = '{
      2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

   // S-box contents, row-major (row 0 col 0 is the leftmost hex digit).
   localparam logic [255:0] S1_T = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
   localparam logic [255:0] S2_T = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
   localparam logic [255:0] S3_T = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
   localparam logic [255:0] S4_T = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
   localparam logic [255:0] S5_T = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
   localparam logic [255:0] S6_T = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
   localparam logic [255:0] S7_T = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
   localparam logic [255:0] S8_T = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

   function automatic logic [63:0] ip(input logic [63:0] x);
      logic [63:0] o;
      for (int i = 0; i < 64; i++) o[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
      return o;
   endfunction

   function automatic logic [63:0] fp(input logic [63:0] x);
      logic [63:0] o;
      for (int i = 0; i < 64; i++) o[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
      return o;
   endfunction

   function automatic logic [47:0] expand(input logic [31:0] x);
      logic [47:0] o;
      for (int i = 0; i < 48; i++) o[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
      return o;
   endfunction

   function automatic logic [31:0] pperm(input logic [31:0] x);
      logic [31:0] o;
      for (int i = 0; i < 32; i++) o[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
      return o;
   endfunction

   function automatic logic [55:0] pc1(input logic [63:0] x);
      logic [55:0] o;
      for (int i = 0; i < 56; i++) o[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
      return o;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] x);
      logic [47:0] o;
      for (int i = 0; i < 48; i++) o[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
      return o;
   endfunction

   function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] n,
                                         input logic right);
      case (n)
         2'd1:    return right ? {x[0], x[27:1]} : {x[26:0], x[27]};
         2'd2:    return right ? {x[1:0], x[27:2]} : {x[25:0], x[27:26]};
         default: return x;
      endcase
   endfunction

   function automatic logic [1:0] shift_amt(input logic dec, input logic [3:0] rnd);
      return dec ? DEC_SH[rnd] : ENC_SH[rnd];
   endfunction

   // Row from the outer bits, column from the inner four.
   function automatic logic [3:0] sbox_lookup(input logic [255:0] tbl, input logic [5:0] g);
      logic [5:0] idx;
      idx = {g[5], g[0], g[4:1]};
      return tbl[{~idx, 2'b11} -: 4];
   endfunction

endpackage

// File: rtl/des_f.sv
// Combinational DES round function f(R, K) = P(S(E(R) ^ K)).
module des_f import des_pkg::*; (
   input  logic [31:0] r,
   input  logic [47:0] k,
   output logic [31:0] f
);

   logic [47:0] x;
   logic [31:0] s;

   assign x = expand(r) ^ k;

   des_s1 u_s1 (.in(x[47:42]), .out(s[31:28]));
   des_s2 u_s2 (.in(x[41:36]), .out(s[27:24]));
   des_s3 u_s3 (.in(x[35:30]), .out(s[23:20]));
   des_s4 u_s4 (.in(x[29:24]), .out(s[19:16]));
   des_s5 u_s5 (.in(x[23:18]), .out(s[15:12]));
   des_s6 u_s6 (.in(x[17:12]), .out(s[11:8]));
   des_s7 u_s7 (.in(x[11:6]),  .out(s[7:4]));
   des_s8 u_s8 (.in(x[5:0]),   .out(s[3:0]));

   assign f = pperm(s);

endmodule

// File: rtl/des_sbox.sv
// The eight DES S-boxes; in[6] is the first FIPS bit of the group, out[4] the first output bit.
module des_s1 import des_pkg::*; (input logic [6:1] in, output logic [4:1] out);
   assign out = sbox_lookup(S1_T, in);
endmodule

module des_s2 import des_pkg::*; (input logic [6:1] in, output logic [4:1] out);
   assign out = sbox_lookup(S2_T, in);
endmodule

module des_s3 import des_pkg::*; (input logic [6:1] in, output logic [4:1] out);
   assign out = sbox_lookup(S3_T, in);
endmodule

module des_s4 import des_pkg::*; (input logic [6:1] in, output logic [4:1] out);
   assign out = sbox_lookup(S4_T, in);
endmodule

module des_s5 import des_pkg::*; (input logic [6:1] in, output logic [4:1] out);
   assign out = sbox_lookup(S5_T, in);
endmodule

module des_s6 import des_pkg::*; (input logic [6:1] in, output logic [4:1] out);
   assign out = sbox_lookup(S6_T, in);
endmodule

module des_s7 import des_pkg::*; (input logic [6:1] in, output logic [4:1] out);
   assign out = sbox_lookup(S7_T, in);
endmodule

module des_s8 import des_pkg::*; (input logic [6:1] in, output logic [4:1] out);
   assign out = sbox_lookup(S8_T, in);
endmodule

// File: rtl/des_round_engine.sv
// Iterative DES encrypt/decrypt engine: one Feistel round per clock, on-the-fly subkeys.
module des_round_engine import des_pkg::*; (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_decrypt,
   input  logic [63:0] in_block,
   input  logic [63:0] in_key,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_block
);

   state_t              state_q, state_d;
   logic [HALF_W-1:0]   l_q, l_d, r_q, r_d;
   logic [CD_W-1:0]     c_q, c_d, d_q, d_d;
   logic [RND_W-1:0]    rnd_q, rnd_d;
   logic                mode_q, mode_d;
   logic                out_valid_d, in_ready_d;
   logic [BLK_W-1:0]    out_block_d;

   logic [1:0]          sh;
   logic [CD_W-1:0]     c_rot, d_rot;
   logic [KEY_W-1:0]    k;
   logic [HALF_W-1:0]   f, r_new;

   // Subkey for the current round: rotate CD (left for encrypt, right for decrypt), then PC-2.
   assign sh    = shift_amt(mode_q, rnd_q);
   assign c_rot = rot28(c_q, sh, mode_q);
   assign d_rot = rot28(d_q, sh, mode_q);
   assign k     = pc2({c_rot, d_rot});

   des_f u_f (.r(r_q), .k(k), .f(f));

   assign r_new = l_q ^ f;

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      l_d         = l_q;
      r_d         = r_q;
      c_d         = c_q;
      d_d         = d_q;
      rnd_d       = rnd_q;
      mode_d      = mode_q;
      out_valid_d = out_valid;
      out_block_d = out_block;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               {l_d, r_d} = ip(in_block);
               {c_d, d_d} = pc1(in_key);
               mode_d     = in_decrypt;
               rnd_d      = '0;
               state_d    = ST_ROUND;
            end
         end
         ST_ROUND: begin
            l_d = r_q;
            r_d = r_new;
            c_d = c_rot;
            d_d = d_rot;
            if (rnd_q == RND_LAST) begin
               // Output {R16, L16}: the last round's swap is undone here.
               out_block_d = fp({r_new, r_q});
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               rnd_d = rnd_q + 4'd1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      in_ready_d = (state_d == ST_IDLE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         l_q       <= '0;
         r_q       <= '0;
         c_q       <= '0;
         d_q       <= '0;
         rnd_q     <= '0;
         mode_q    <= 1'b0;
         out_valid <= 1'b0;
         out_block <= '0;
         in_ready  <= 1'b0;
      end else begin
         state_q   <= state_d;
         l_q       <= l_d;
         r_q       <= r_d;
         c_q       <= c_d;
         d_q       <= d_d;
         rnd_q     <= rnd_d;
         mode_q    <= mode_d;
         out_valid <= out_valid_d;
         out_block <= out_block_d;
         in_ready  <= in_ready_d;
      end
   end

endmodule

// File: tb/tb_des_round_engine.sv
// Bench for des_round_engine: known-answer table, random ops vs. a bit-level DES model,
// backpressure, mid-operation reset and back-to-back sequences.
module tb_des_round_engine;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_decrypt;
   logic [63:0] in_block;
   logic [63:0] in_key;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_block;

   des_round_engine dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt),
      .in_block(in_block), .in_key(in_key),
      .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // ---------------- reference model (FIPS 1-based bit numbering) ----------------
   int ip_t[$], fp_t[$], e_t[$], pc1_t[$], pc2_t[$], p_t[$], sh_t[$];
   logic [255:0] sb [8];

   task automatic build_tables();
      // IP rows start at 58,60,62,64,57,59,61,63 and step down by 8; FP is its inverse.
      for (int i = 0; i < 64; i++) begin
         int row, col, base;
         row  = i / 8;
         col  = i % 8;
         base = (row < 4) ? 58 + 2 * row : 57 + 2 * (row - 4);
         ip_t.push_back(base - 8 * col);
         fp_t.push_back(0);
      end
      for (int j = 0; j < 64; j++) fp_t[ip_t[j] - 1] = j + 1;
      // E: group g repeats bits 4g..4g+5 with wraparound.
      for (int i = 0; i < 48; i++) begin
         int s;
         s = 4 * (i / 6) + (i % 6);
         if (s == 0) s = 32;
         if (s == 33) s = 1;
         e_t.push_back(s);
      end
      pc1_t = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
      pc2_t = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
      p_t   = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
      sh_t  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
      sb[0] = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
      sb[1] = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
      sb[2] = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
      sb[3] = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
      sb[4] = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
      sb[5] = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
      sb[6] = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
      sb[7] = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
   endtask

   // Output FIPS bit n takes input FIPS bit tbl[n-1]; result right-aligned.
   function automatic logic [63:0] permute(input logic [63:0] v, input int iw, input int tbl[$]);
      logic [63:0] o;
      int ow;
      o  = '0;
      ow = tbl.size();
      for (int n = 1; n <= ow; n++) o[6'(ow - n)] = v[6'(iw - tbl[n - 1])];
      return o;
   endfunction

   function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] ex;
      logic [31:0] s;
      logic [5:0]  six;
      int          row, col;
      ex = 48'(permute({32'd0, r}, 32, e_t)) ^ k;
      s  = '0;
      for (int g = 0; g < 8; g++) begin
         six = 6'(ex >> (42 - 6 * g));
         row = 2 * int'(six[5]) + int'(six[0]);
         col = int'(six[4:1]);
         s   = {s[27:0], 4'(sb[3'(g)] >> (252 - 4 * (16 * row + col)))};
      end
      return 32'(permute({32'd0, s}, 32, p_t));
   endfunction

   // All 16 subkeys precomputed by cumulative left shifts; decryption uses them in reverse.
   function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk,
                                           input logic dec);
      logic [55:0] cd;
      logic [27:0] c, d;
      logic [47:0] ks [16];
      logic [63:0] x;
      logic [31:0] l, r, t;
      cd = 56'(permute(key, 64, pc1_t));
      c  = cd[55:28];
      d  = cd[27:0];
      for (int i = 0; i < 16; i++) begin
         for (int s = 0; s < sh_t[i]; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         ks[4'(i)] = 48'(permute({8'd0, c, d}, 56, pc2_t));
      end
      x = permute(blk, 64, ip_t);
      l = x[63:32];
      r = x[31:0];
      for (int i = 0; i < 16; i++) begin
         t = l ^ feistel(r, dec ? ks[4'(15 - i)] : ks[4'(i)]);
         l = r;
         r = t;
      end
      return permute({r, l}, 64, fp_t);
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One full transaction; returns result and cycles from accept edge to out_valid.
   task automatic run_op(input logic [63:0] key, input logic [63:0] blk, input logic dec,
                         input int hold, output logic [63:0] res, output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      in_key     = key;
      in_block   = blk;
      in_decrypt = dec;
      in_valid   = 1'b1;
      @(negedge clk);
      in_valid   = 1'b0;
      in_key     = {$urandom, $urandom};
      in_block   = {$urandom, $urandom};
      in_decrypt = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      res = out_block;
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   typedef struct {
      logic [63:0] key;
      logic [63:0] blk;
      logic        dec;
      logic [63:0] exp;
   } vec_t;

   vec_t        vt [6];
   logic [63:0] res, ref_v, held, rk, rb, b2b_res [2];
   logic        rd, seen;
   int          lat, acc_n, res_n, b2b_acc [2];
   bit          switched;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      build_tables();
      vt[0] = '{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405};
      vt[1] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF};
      vt[2] = '{64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000};
      vt[3] = '{64'h0F339333EB6C0C72, 64'h8787878787878787, 1'b0, 64'h0000000000000000};
      vt[4] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b1, 64'h8787878787878787};
      vt[5] = '{64'h0000000000000000, 64'h0000000000000000, 1'b0, 64'h8CA64DE9C1B123A7};

      rst = 1'b1; in_valid = 1'b0; in_decrypt = 1'b0; in_block = '0; in_key = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset in_ready", 64'(in_ready), 64'd0);
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset out_block", out_block, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready after release", 64'(in_ready), 64'd1);

      // Known-answer table.
      for (int i = 0; i < 6; i++) begin
         run_op(vt[i].key, vt[i].blk, vt[i].dec, i % 3, res, lat);
         chk($sformatf("kat%0d result", i), res, vt[i].exp);
         chk($sformatf("kat%0d latency", i), 64'(lat), 64'd16);
         chk($sformatf("kat%0d in_ready after handshake", i), 64'(in_ready), 64'd1);
      end

      // Random ops against the model.
      for (int i = 0; i < 12; i++) begin
         rk = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rd = 1'($urandom);
         ref_v = des_ref(rk, rb, rd);
         run_op(rk, rb, rd, $urandom_range(0, 3), res, lat);
         chk($sformatf("rand%0d result", i), res, ref_v);
         chk($sformatf("rand%0d out_valid cleared", i), 64'(out_valid), 64'd0);
      end

      // Backpressure: result held, pending request ignored through DONE and its handshake edge.
      in_key = 64'h133457799BBCDFF1; in_block = 64'h0123456789ABCDEF; in_decrypt = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      in_block = 64'hFFFFFFFFFFFFFFFF;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("bp latency", 64'(lat), 64'd16);
      held = out_block;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp%0d out_block", i), out_block, 64'h85E813540F0AB405);
         chk($sformatf("bp%0d out_valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("bp%0d in_ready", i), 64'(in_ready), 64'd0);
      end
      chk("bp held value", out_block, held);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("bp out_valid after handshake", 64'(out_valid), 64'd0);
      chk("bp in_ready after handshake", 64'(in_ready), 64'd1);
      @(negedge clk);
      chk("bp no accept in DONE", 64'(in_ready), 64'd1);

      // Reset while rnd = 7.
      in_key = 64'h133457799BBCDFF1; in_block = 64'h0123456789ABCDEF; in_decrypt = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst out_valid", 64'(out_valid), 64'd0);
      chk("midrst in_ready during rst", 64'(in_ready), 64'd0);
      @(negedge clk);
      chk("midrst in_ready idle", 64'(in_ready), 64'd1);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("midrst discarded", 64'(seen), 64'd0);
      run_op(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 0, res, lat);
      chk("midrst resubmit", res, 64'h85E813540F0AB405);

      // Back-to-back: encrypt then decrypt of its result, in_valid and out_ready held high.
      out_ready = 1'b1;
      in_key = 64'h133457799BBCDFF1; in_block = 64'h0123456789ABCDEF; in_decrypt = 1'b0;
      in_valid = 1'b1;
      acc_n = 0; res_n = 0; switched = 1'b0;
      for (int i = 0; i < 80 && res_n < 2; i++) begin
         if (out_valid && res_n < 2) begin
            b2b_res[res_n] = out_block;
            res_n++;
         end
         if (acc_n == 1 && !switched) begin
            in_block   = 64'h85E813540F0AB405;
            in_decrypt = 1'b1;
            switched   = 1'b1;
         end
         if (acc_n == 2) in_valid = 1'b0;
         if (in_valid && in_ready && acc_n < 2) begin
            b2b_acc[acc_n] = cyc + 1;
            acc_n++;
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("b2b accepts", 64'(acc_n), 64'd2);
      chk("b2b results", 64'(res_n), 64'd2);
      if (acc_n == 2) chk("b2b spacing", 64'(b2b_acc[1] - b2b_acc[0]), 64'd18);
      if (res_n == 2) begin
         chk("b2b encrypt", b2b_res[0], 64'h85E813540F0AB405);
         chk("b2b decrypt", b2b_res[1], 64'h0123456789ABCDEF);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
